// File: rtl/chip8_fetch.sv
// CHIP-8 instruction fetch: owns the program counter, reads two bytes big-endian
// from chip8_mem and hands the 16-bit opcode to the decoder over valid/ready.
//
// state  | meaning
// IDLE   | waiting for fetch_req; PC may be loaded or skipped
// RD_HI  | high-byte address (pc) presented to memory
// CAP_HI | capture high byte; low-byte address (pc+1) presented
// CAP_LO | capture low byte; advance pc by 2
// VALID  | opcode held until the decoder accepts it
module chip8_fetch #(
  parameter logic [11:0] RESET_PC = 12'h200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic        opcode_ready,
  input  logic        pc_load,
  input  logic [11:0] pc_load_addr,
  input  logic        pc_skip,
  input  logic [7:0]  mem_data_out,
  output logic        mem_read,
  output logic [11:0] mem_address,
  output logic [15:0] opcode,
  output logic        opcode_valid,
  output logic [11:0] pc,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_HI  = 3'd1,
    CAP_HI = 3'd2,
    CAP_LO = 3'd3,
    VALID  = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic [11:0] pc_nxt;
  logic [15:0] opcode_nxt;
  logic        valid_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      opcode       <= 16'h0000;
      opcode_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      opcode       <= opcode_nxt;
      opcode_valid <= valid_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    opcode_nxt = opcode;
    valid_nxt  = opcode_valid;

    case (state)
      IDLE:    if (fetch_req) state_nxt = RD_HI;
      RD_HI:   state_nxt = CAP_HI;
      CAP_HI: begin
        opcode_nxt[15:8] = mem_data_out;
        state_nxt        = CAP_LO;
      end
      CAP_LO: begin
        opcode_nxt[7:0] = mem_data_out;
        pc_nxt          = pc + 12'd2;
        valid_nxt       = 1'b1;
        state_nxt       = VALID;
      end
      VALID: begin
        if (opcode_ready) begin
          valid_nxt = 1'b0;
          state_nxt = fetch_req ? RD_HI : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A load aborts everything in flight, including a byte capture this cycle.
    if (pc_load) begin
      pc_nxt     = pc_load_addr;
      opcode_nxt = opcode;
      valid_nxt  = 1'b0;
      state_nxt  = IDLE;
    end else if (pc_skip && (state == IDLE || state == VALID)) begin
      pc_nxt    = pc + 12'd2;
      valid_nxt = 1'b0;
      state_nxt = IDLE;
    end
  end

  always_comb begin
    mem_read    = (state == RD_HI) || (state == CAP_HI);
    mem_address = (state == CAP_HI) ? pc + 12'd1 : pc;
    busy        = (state == RD_HI) || (state == CAP_HI) || (state == CAP_LO);
  end

endmodule

// File: tb/tb_chip8_fetch.sv
// Directed bench for chip8_fetch with a behavioural one-cycle-latency memory.
module tb_chip8_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req, opcode_ready, pc_load, pc_skip;
  logic [11:0] pc_load_addr;
  logic [7:0]  mem_data_out;
  logic        mem_read;
  logic [11:0] mem_address;
  logic [15:0] opcode;
  logic        opcode_valid;
  logic [11:0] pc;
  logic        busy;

  logic [7:0] mem [0:4095];
  int err_cnt = 0;
  int chk_cnt = 0;

  chip8_fetch #(.RESET_PC(12'h200)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .opcode_ready(opcode_ready),
    .pc_load(pc_load), .pc_load_addr(pc_load_addr), .pc_skip(pc_skip),
    .mem_data_out(mem_data_out), .mem_read(mem_read), .mem_address(mem_address),
    .opcode(opcode), .opcode_valid(opcode_valid), .pc(pc), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_read) mem_data_out <= mem[mem_address];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h200] = 8'h00; mem[12'h201] = 8'hE0;
    mem[12'h202] = 8'h12; mem[12'h203] = 8'h34;
    mem[12'h300] = 8'h6A; mem[12'h301] = 8'h05;
    mem[12'hFFF] = 8'hA2; mem[12'h000] = 8'hF0;
    mem[12'h400] = 8'h99;
    mem_data_out = 8'h00;
    rst_n = 1'b0; fetch_req = 1'b0; opcode_ready = 1'b0;
    pc_load = 1'b0; pc_skip = 1'b0; pc_load_addr = 12'h000;

    #12;
    check("rst_pc", pc, 12'h200);
    check("rst_opcode", opcode, 16'h0000);
    check("rst_valid", opcode_valid, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_addr", mem_address, 12'h200);
    check("rst_busy", busy, 0);

    @(negedge clk); rst_n = 1'b1;
    fetch_req = 1'b1;
    tick();                               // RD_HI
    check("rdhi_read", mem_read, 1);
    check("rdhi_addr", mem_address, 12'h200);
    check("rdhi_busy", busy, 1);
    tick();                               // CAP_HI
    check("caphi_read", mem_read, 1);
    check("caphi_addr", mem_address, 12'h201);
    tick();                               // CAP_LO
    check("caplo_read", mem_read, 0);
    check("caplo_valid", opcode_valid, 0);
    tick();                               // VALID
    check("basic_valid", opcode_valid, 1);
    check("basic_opcode", opcode, 16'h00E0);
    check("basic_pc", pc, 12'h202);
    check("basic_busy", busy, 0);

    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_opcode", opcode, 16'h00E0);
      check("bp_valid", opcode_valid, 1);
    end
    opcode_ready = 1'b1;
    tick();                               // back-to-back into RD_HI
    opcode_ready = 1'b0;
    check("b2b_valid_drop", opcode_valid, 0);
    check("b2b_addr", mem_address, 12'h202);
    check("b2b_read", mem_read, 1);
    tick(); tick(); tick();
    check("b2b_valid", opcode_valid, 1);
    check("b2b_opcode", opcode, 16'h1234);
    check("b2b_pc", pc, 12'h204);

    fetch_req = 1'b0; pc_skip = 1'b1;
    tick();
    pc_skip = 1'b0;
    check("skip_valid", opcode_valid, 0);
    check("skip_pc", pc, 12'h206);
    check("skip_idle", busy, 0);

    pc_load = 1'b1; pc_skip = 1'b1; pc_load_addr = 12'h400;
    tick();
    pc_load = 1'b0; pc_skip = 1'b0;
    check("load_skip_pc", pc, 12'h400);

    fetch_req = 1'b1;
    tick(); tick();                       // CAP_HI
    check("abort_in_caphi", mem_address, 12'h401);
    pc_load = 1'b1; pc_load_addr = 12'h300;
    tick();
    pc_load = 1'b0;
    check("abort_pc", pc, 12'h300);
    check("abort_valid", opcode_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_read", mem_read, 0);
    tick();
    check("jmp_addr_hi", mem_address, 12'h300);
    tick();
    check("jmp_addr_lo", mem_address, 12'h301);
    tick(); tick();
    check("jmp_opcode", opcode, 16'h6A05);
    check("jmp_valid", opcode_valid, 1);
    check("jmp_pc", pc, 12'h302);
    fetch_req = 1'b0; opcode_ready = 1'b1;
    tick();
    opcode_ready = 1'b0;
    check("accept_idle_valid", opcode_valid, 0);
    check("accept_idle_opcode", opcode, 16'h6A05);

    pc_load = 1'b1; pc_load_addr = 12'hFFF;
    tick();
    pc_load = 1'b0; fetch_req = 1'b1;
    tick();
    check("wrap_addr_hi", mem_address, 12'hFFF);
    tick();
    check("wrap_addr_lo", mem_address, 12'h000);
    fetch_req = 1'b0;
    tick(); tick();
    check("wrap_opcode", opcode, 16'hA2F0);
    check("wrap_pc", pc, 12'h001);
    opcode_ready = 1'b1;
    tick();
    opcode_ready = 1'b0;

    pc_load = 1'b1; pc_load_addr = 12'hFFE;
    tick();
    pc_load = 1'b0; pc_skip = 1'b1;
    tick();
    pc_skip = 1'b0;
    check("skip_wrap_pc", pc, 12'h000);

    fetch_req = 1'b1;
    tick(); tick(); tick();               // CAP_LO
    check("midrst_busy", busy, 1);
    check("midrst_read_pre", mem_read, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_pc", pc, 12'h200);
    check("midrst_valid", opcode_valid, 0);
    check("midrst_read", mem_read, 0);
    check("midrst_opcode", opcode, 16'h0000);
    check("midrst_busy_clr", busy, 0);
    fetch_req = 1'b0;
    tick();
    check("midrst_hold_pc", pc, 12'h200);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
